// File: rtl/button_conditioner.sv
// Multi-channel button front end: two-flop synchroniser, per-channel debounce FSM,
// single-cycle press pulse, debounced level, and any/multi press flags.
module button_conditioner #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_in,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic                 any_press,
  output logic                 multi_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'b00,
    PRESS_CHK   = 2'b01,
    PRESSED     = 2'b10,
    RELEASE_CHK = 2'b11
  } state_t;

  function automatic logic more_than_one(input logic [N_BUTTONS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      n = n + int'(v[i]);
    end
    return (n > 1);
  endfunction

  logic [N_BUTTONS-1:0] s1_p1;
  logic [N_BUTTONS-1:0] s2_p2;

  // Stage p1/p2: metastability synchroniser; only s2_p2 feeds the FSMs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_p1 <= '0;
      s2_p2 <= '0;
    end else begin
      s1_p1 <= btn_in;
      s2_p2 <= s1_p1;
    end
  end

  // Stage p3: per-channel debounce FSM with registered pulse and level
  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_d, level_d;
    logic             pulse_p3, level_p3;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= RELEASED;
        cnt_q    <= '0;
        pulse_p3 <= 1'b0;
        level_p3 <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        pulse_p3 <= pulse_d;
        level_p3 <= level_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
        RELEASED: begin
          if (s2_p2[g]) begin
            state_d = PRESS_CHK;
            cnt_d   = '0;
          end
        end
        PRESS_CHK: begin
          if (!s2_p2[g]) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = PRESSED;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!s2_p2[g]) begin
            state_d = RELEASE_CHK;
            cnt_d   = '0;
          end
        end
        RELEASE_CHK: begin
          if (s2_p2[g]) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
      // Level is registered from the next state so it moves on the same edge as the pulse
      level_d = (state_d == PRESSED) || (state_d == RELEASE_CHK);
    end

    assign press_pulse[g] = pulse_p3;
    assign btn_level[g]   = level_p3;
  end

  assign any_press   = |press_pulse;
  assign multi_press = more_than_one(press_pulse);

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed vector table, hand-written corner
// sequences, and randomized stimulus against a run-length reference model.
module tb_button_conditioner;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] press_pulse;
  logic [N-1:0] btn_level;
  logic         any_press;
  logic         multi_press;

  int n_checks = 0;
  int n_fail   = 0;

  button_conditioner #(
    .N_BUTTONS      (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .press_pulse(press_pulse),
    .btn_level  (btn_level),
    .any_press  (any_press),
    .multi_press(multi_press)
  );

  always #5 clk = ~clk;

  // Reference model: a level flips once the synchronised input has disagreed
  // with it for D+1 consecutive samples; a flip to 1 is a press.
  logic [N-1:0] m_s1, m_s2, m_level, m_pulse;
  int           m_run [N];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_pulse = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      m_pulse[i] = 1'b0;
      if (m_s2[i] != m_level[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == D + 1) begin
          m_level[i] = ~m_level[i];
          m_pulse[i] = m_level[i];
          m_run[i]   = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_in;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [N-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < N; i++) n = n + int'(v[i]);
    return n;
  endfunction

  // One clock: advance the model on the edge, compare on the falling edge
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    chk("press_pulse", 32'(press_pulse), 32'(m_pulse));
    chk("btn_level",   32'(btn_level),   32'(m_level));
    chk("any_press",   32'(any_press),   32'(m_pulse != '0));
    chk("multi_press", 32'(multi_press), 32'(popc(m_pulse) > 1));
  endtask

  typedef struct {
    logic [N-1:0] btn;
    int           hold;
    logic [N-1:0] exp_pulse;
    int           exp_pedge;
    int           exp_npc;
    logic [N-1:0] exp_level;
    int           exp_ledge;
    logic         exp_any;
    logic         exp_multi;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [N-1:0] pulse_or, lvl0, seen_lvl;
    int           pedge, npc, ledge, cnt;
    logic         any_at, multi_at, lvl_low;

    vecs[0] = '{4'b1000, 20,  4'b1000, 7, 1, 4'b1000, 7, 1'b1, 1'b0};
    vecs[1] = '{4'b0000, 20,  4'b0000, 0, 0, 4'b0000, 7, 1'b0, 1'b0};
    vecs[2] = '{4'b0101, 20,  4'b0101, 7, 1, 4'b0101, 7, 1'b1, 1'b1};
    vecs[3] = '{4'b0000, 20,  4'b0000, 0, 0, 4'b0000, 7, 1'b0, 1'b0};
    vecs[4] = '{4'b0100, 100, 4'b0100, 7, 1, 4'b0100, 7, 1'b1, 1'b0};
    vecs[5] = '{4'b0000, 20,  4'b0000, 0, 0, 4'b0000, 7, 1'b0, 1'b0};

    model_reset();
    @(negedge clk);
    chk("reset press_pulse", 32'(press_pulse), 32'd0);
    chk("reset btn_level",   32'(btn_level),   32'd0);
    chk("reset any_press",   32'(any_press),   32'd0);
    chk("reset multi_press", 32'(multi_press), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) tick();

    // Directed vector table
    for (int r = 0; r < 6; r++) begin
      btn_in   = vecs[r].btn;
      lvl0     = btn_level;
      pulse_or = '0; pedge = 0; npc = 0; ledge = 0; any_at = 1'b0; multi_at = 1'b0;
      for (int k = 1; k <= vecs[r].hold; k++) begin
        tick();
        pulse_or |= press_pulse;
        if (press_pulse != '0) begin
          npc++;
          if (pedge == 0) begin
            pedge    = k;
            any_at   = any_press;
            multi_at = multi_press;
          end
        end
        if (ledge == 0 && btn_level != lvl0) ledge = k;
      end
      chk($sformatf("vec%0d pulse", r),       32'(pulse_or),  32'(vecs[r].exp_pulse));
      chk($sformatf("vec%0d pulse_edge", r),  32'(pedge),     32'(vecs[r].exp_pedge));
      chk($sformatf("vec%0d pulse_cycles", r), 32'(npc),      32'(vecs[r].exp_npc));
      chk($sformatf("vec%0d level", r),       32'(btn_level), 32'(vecs[r].exp_level));
      chk($sformatf("vec%0d level_edge", r),  32'(ledge),     32'(vecs[r].exp_ledge));
      chk($sformatf("vec%0d any", r),         32'(any_at),    32'(vecs[r].exp_any));
      chk($sformatf("vec%0d multi", r),       32'(multi_at),  32'(vecs[r].exp_multi));
    end

    // Press bounce: 2 high, 1 low, four times
    pulse_or = '0; seen_lvl = '0;
    for (int rep = 0; rep < 4; rep++) begin
      btn_in = 4'b0010;
      for (int k = 0; k < 2; k++) begin tick(); pulse_or |= press_pulse; seen_lvl |= btn_level; end
      btn_in = 4'b0000;
      tick(); pulse_or |= press_pulse; seen_lvl |= btn_level;
    end
    for (int k = 0; k < 10; k++) begin tick(); pulse_or |= press_pulse; seen_lvl |= btn_level; end
    chk("bounce pulse", 32'(pulse_or), 32'd0);
    chk("bounce level", 32'(seen_lvl), 32'd0);

    // Reset during PRESS_CHK with the button held
    btn_in = 4'b0001;
    pulse_or = '0;
    for (int k = 0; k < 3; k++) begin tick(); pulse_or |= press_pulse; end
    rst = 1'b1;
    tick();
    pulse_or |= press_pulse;
    chk("rst_mid pulse before", 32'(pulse_or), 32'd0);
    rst = 1'b0;
    pedge = 0; cnt = 0; pulse_or = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (press_pulse != '0) begin
        cnt++;
        pulse_or |= press_pulse;
        if (pedge == 0) pedge = k;
      end
    end
    chk("rst_mid pulse edge",  32'(pedge),    32'd7);
    chk("rst_mid pulse count", 32'(cnt),      32'd1);
    chk("rst_mid pulse value", 32'(pulse_or), 32'd1);
    btn_in = 4'b0000;
    for (int k = 0; k < 20; k++) tick();

    // Release bounce while held
    btn_in = 4'b1000;
    for (int k = 0; k < 20; k++) tick();
    btn_in = 4'b0000;
    cnt = 0; lvl_low = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick(); cnt += popc(press_pulse); lvl_low |= ~btn_level[3];
    end
    btn_in = 4'b1000;
    for (int k = 0; k < 20; k++) begin
      tick(); cnt += popc(press_pulse); lvl_low |= ~btn_level[3];
    end
    chk("rel_bounce pulses",   32'(cnt),     32'd0);
    chk("rel_bounce level low", 32'(lvl_low), 32'd0);
    btn_in = 4'b0000;
    for (int k = 0; k < 20; k++) tick();

    // Randomized stimulus with occasional resets
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) btn_in[i] = ~btn_in[i];
      end
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
